// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
interface ifetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_err;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata, imem_err);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata, imem_err);
endinterface

// File: rtl/ifetch_unit.sv
// Multicycle instruction fetch: latches PC, handshakes with imem, loads IR,
// and reports misaligned / bus-error / timeout as sticky faults.
module ifetch_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] IR_RESET       = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_start,
   input  logic                 flush,
   input  logic                 fault_clr,
   input  logic [31:0]          PC,
   ifetch_unit_if.master        imem,
   output logic [31:0]          IR,
   output logic [31:0]          IR_pc,
   output logic                 fetch_done,
   output logic                 fetch_busy,
   output logic                 fault,
   output logic [1:0]           fault_cause
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_BUS   = 2'b10;
   localparam logic [1:0] CAUSE_TMO   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             req_q, req_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      ir_q, ir_d;
   logic [31:0]      ir_pc_q, ir_pc_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and all output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= 32'h0;
         ir_q    <= IR_RESET;
         ir_pc_q <= 32'h0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         ir_pc_q <= ir_pc_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and next-output logic; flush outranks any same-cycle response
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      ir_pc_d = ir_pc_q;
      done_d  = 1'b0;
      fault_d = fault_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (fetch_start && !flush) begin
               addr_d = PC;
               if (PC[1:0] != 2'b00) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
                  cause_d = CAUSE_ALIGN;
               end else begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end else if (req_q && imem.imem_ready) begin
               req_d = 1'b0;
               if (imem.imem_err) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
                  cause_d = CAUSE_BUS;
               end else begin
                  state_d = S_IDLE;
                  ir_d    = imem.imem_rdata;
                  ir_pc_d = addr_q;
                  done_d  = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FAULT;
               req_d   = 1'b0;
               fault_d = 1'b1;
               cause_d = CAUSE_TMO;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FAULT: begin
            if (fault_clr) begin
               state_d = S_IDLE;
               fault_d = 1'b0;
               cause_d = CAUSE_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign IR             = ir_q;
   assign IR_pc          = ir_pc_q;
   assign fetch_done     = done_q;
   assign fetch_busy     = req_q;
   assign fault          = fault_q;
   assign fault_cause    = cause_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: inputs change and outputs are checked on negedge.
module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic        fetch_start;
   logic        flush;
   logic        fault_clr;
   logic [31:0] PC;
   logic [31:0] IR;
   logic [31:0] IR_pc;
   logic        fetch_done;
   logic        fetch_busy;
   logic        fault;
   logic [1:0]  fault_cause;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   ifetch_unit_if imem ();

   ifetch_unit #(
      .TIMEOUT_CYCLES (4),
      .IR_RESET       (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .flush       (flush),
      .fault_clr   (fault_clr),
      .PC          (PC),
      .imem        (imem),
      .IR          (IR),
      .IR_pc       (IR_pc),
      .fetch_done  (fetch_done),
      .fetch_busy  (fetch_busy),
      .fault       (fault),
      .fault_cause (fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      fetch_start = 1'b0;
      flush = 1'b0;
      fault_clr = 1'b0;
      PC = 32'h0;
      imem.imem_ready = 1'b0;
      imem.imem_rdata = 32'h0;
      imem.imem_err = 1'b0;

      // Reset values
      #1 rst = 1'b0;
      #1;
      check("rst_req",   32'(imem.imem_req), 32'd0);
      check("rst_addr",  imem.imem_addr, 32'h0);
      check("rst_ir",    IR, 32'h0000_0013);
      check("rst_irpc",  IR_pc, 32'h0);
      check("rst_done",  32'(fetch_done), 32'd0);
      check("rst_busy",  32'(fetch_busy), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_cause", 32'(fault_cause), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Zero-wait fetch
      @(negedge clk);
      PC = 32'h0000_0010;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("zw_req",  32'(imem.imem_req), 32'd1);
      check("zw_busy", 32'(fetch_busy), 32'd1);
      check("zw_addr", imem.imem_addr, 32'h0000_0010);
      check("zw_done0", 32'(fetch_done), 32'd0);
      imem.imem_ready = 1'b1;
      imem.imem_rdata = 32'h0050_0093;
      @(negedge clk);
      imem.imem_ready = 1'b0;
      check("zw_ir",    IR, 32'h0050_0093);
      check("zw_irpc",  IR_pc, 32'h0000_0010);
      check("zw_done",  32'(fetch_done), 32'd1);
      check("zw_req0",  32'(imem.imem_req), 32'd0);
      check("zw_fault", 32'(fault), 32'd0);
      @(negedge clk);
      check("zw_done_pulse", 32'(fetch_done), 32'd0);

      // Three wait cycles; PC moves while the request is outstanding
      PC = 32'h0000_0100;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      PC = 32'h0000_0020;
      for (int i = 1; i <= 4; i++) begin
         check("w3_req",  32'(imem.imem_req), 32'd1);
         check("w3_addr", imem.imem_addr, 32'h0000_0100);
         check("w3_done0", 32'(fetch_done), 32'd0);
         if (i == 4) begin
            imem.imem_ready = 1'b1;
            imem.imem_rdata = 32'h00B5_0533;
         end
         @(negedge clk);
      end
      imem.imem_ready = 1'b0;
      check("w3_ir",   IR, 32'h00B5_0533);
      check("w3_irpc", IR_pc, 32'h0000_0100);
      check("w3_done", 32'(fetch_done), 32'd1);
      check("w3_req0", 32'(imem.imem_req), 32'd0);

      // Misaligned PC, fault holds against start and flush until cleared
      @(negedge clk);
      PC = 32'h0000_0102;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("mis_req",   32'(imem.imem_req), 32'd0);
      check("mis_fault", 32'(fault), 32'd1);
      check("mis_cause", 32'(fault_cause), 32'd1);
      PC = 32'h0000_0200;
      fetch_start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      flush = 1'b0;
      check("mis_hold_req",   32'(imem.imem_req), 32'd0);
      check("mis_hold_fault", 32'(fault), 32'd1);
      check("mis_hold_cause", 32'(fault_cause), 32'd1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("mis_clr_fault", 32'(fault), 32'd0);
      check("mis_clr_cause", 32'(fault_cause), 32'd0);
      check("mis_clr_req",   32'(imem.imem_req), 32'd0);

      // Timeout: request held exactly 4 cycles
      PC = 32'h0000_0300;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("tmo_req", 32'(imem.imem_req), 32'd1);
         check("tmo_nofault", 32'(fault), 32'd0);
         @(negedge clk);
      end
      check("tmo_req0",  32'(imem.imem_req), 32'd0);
      check("tmo_fault", 32'(fault), 32'd1);
      check("tmo_cause", 32'(fault_cause), 32'd3);
      check("tmo_ir",    IR, 32'h00B5_0533);
      check("tmo_irpc",  IR_pc, 32'h0000_0100);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("tmo_clr", 32'(fault), 32'd0);

      // Bus error on the response
      PC = 32'h0000_0400;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("err_req", 32'(imem.imem_req), 32'd1);
      imem.imem_ready = 1'b1;
      imem.imem_err = 1'b1;
      imem.imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem.imem_ready = 1'b0;
      imem.imem_err = 1'b0;
      check("err_fault", 32'(fault), 32'd1);
      check("err_cause", 32'(fault_cause), 32'd2);
      check("err_ir",    IR, 32'h00B5_0533);
      check("err_irpc",  IR_pc, 32'h0000_0100);
      check("err_done",  32'(fetch_done), 32'd0);
      check("err_req0",  32'(imem.imem_req), 32'd0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;

      // Flush wins over a same-cycle response
      PC = 32'h0000_0500;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("fl_req", 32'(imem.imem_req), 32'd1);
      imem.imem_ready = 1'b1;
      imem.imem_rdata = 32'hDEAD_BEEF;
      flush = 1'b1;
      @(negedge clk);
      imem.imem_ready = 1'b0;
      flush = 1'b0;
      check("fl_req0",  32'(imem.imem_req), 32'd0);
      check("fl_done",  32'(fetch_done), 32'd0);
      check("fl_fault", 32'(fault), 32'd0);
      check("fl_ir",    IR, 32'h00B5_0533);
      fetch_start = 1'b1;
      flush = 1'b1;
      PC = 32'h0000_0600;
      @(negedge clk);
      fetch_start = 1'b0;
      flush = 1'b0;
      check("fl_idle_req",  32'(imem.imem_req), 32'd0);
      check("fl_idle_busy", 32'(fetch_busy), 32'd0);

      // Asynchronous reset in the middle of a wait
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("ar_req", 32'(imem.imem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("ar_req0",  32'(imem.imem_req), 32'd0);
      check("ar_ir",    IR, 32'h0000_0013);
      check("ar_irpc",  IR_pc, 32'h0);
      check("ar_fault", 32'(fault), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      PC = 32'h0000_0700;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("ar_f_addr", imem.imem_addr, 32'h0000_0700);
      imem.imem_ready = 1'b1;
      imem.imem_rdata = 32'h0000_0073;
      @(negedge clk);
      imem.imem_ready = 1'b0;
      check("ar_f_ir",   IR, 32'h0000_0073);
      check("ar_f_irpc", IR_pc, 32'h0000_0700);
      check("ar_f_done", 32'(fetch_done), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
